// File: rtl/floor_request_encoder.sv
// Floor call encoder: synchronizes and debounces four raw call buttons, priority-encodes
// the accepted vector into a held 2-bit floor code, and offers it through a valid/ack request.
module floor_request_encoder #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] buttons,
  input  logic       ack,
  output logic [1:0] floor_code,
  output logic       req_valid,
  output logic       new_req
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SETTLE  = 2'd1;
  localparam logic [1:0] PENDING = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       sync_p0;
  logic [3:0]       sync_p1;
  logic [3:0]       stored;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       state;

  // Lowest-numbered pressed floor wins.
  function automatic logic [1:0] encode(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0    <= 4'd0;
      sync_p1    <= 4'd0;
      stored     <= 4'd0;
      cnt        <= '0;
      state      <= IDLE;
      floor_code <= 2'd0;
      req_valid  <= 1'b0;
      new_req    <= 1'b0;
    end else begin
      // Stage p0 -> p1: two-flop synchronizer; only sync_p1 feeds the FSM.
      sync_p0 <= buttons;
      sync_p1 <= sync_p0;
      new_req <= 1'b0;
      case (state)
        IDLE: begin
          if (sync_p1 != 4'd0) begin
            state  <= SETTLE;
            stored <= sync_p1;
            cnt    <= CNT_ONE;
          end
        end
        SETTLE: begin
          if (sync_p1 == 4'd0) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (sync_p1 != stored) begin
            stored <= sync_p1;
            cnt    <= CNT_ONE;
          end else if (cnt < CNT_LAST) begin
            cnt <= cnt + CNT_ONE;
          end else begin
            state      <= PENDING;
            cnt        <= '0;
            floor_code <= encode(stored);
            req_valid  <= 1'b1;
            new_req    <= 1'b1;
          end
        end
        PENDING: begin
          // A button still held at ack time must be released before it can request again.
          if (ack) begin
            req_valid <= 1'b0;
            state     <= (sync_p1 != 4'd0) ? RELEASE : IDLE;
          end
        end
        RELEASE: begin
          if (sync_p1 == 4'd0) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_floor_request_encoder.sv
// Directed bench for floor_request_encoder: debounce latency, bounce rejection, priority,
// restart on vector change, ack handshake, release gating and reset abort.
module tb_floor_request_encoder;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] buttons;
  logic       ack;
  logic [1:0] floor_code;
  logic       req_valid;
  logic       new_req;

  int checks = 0;
  int errors = 0;

  floor_request_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clock(clock),
    .reset(reset),
    .buttons(buttons),
    .ack(ack),
    .floor_code(floor_code),
    .req_valid(req_valid),
    .new_req(new_req)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drop all buttons long enough for RELEASE to return to IDLE.
  task automatic release_all();
    buttons = 4'd0;
    ack = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; buttons = 4'd0; ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (floor_code !== 2'd0) begin errors++; $display("FAIL reset_floor_code: got %0d expected 0", floor_code); end
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid); end
    checks++; if (new_req !== 1'b0) begin errors++; $display("FAIL reset_new_req: got %b expected 0", new_req); end
    tick();
  endtask

  task automatic test_basic();
    buttons = 4'b0100;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if ({req_valid, new_req, floor_code} !== 4'b0000) begin errors++; $display("FAIL basic_wait edge %0d: got %b expected 0000", i, {req_valid, new_req, floor_code}); end
    end
    tick();
    checks++; if ({req_valid, new_req, floor_code} !== 4'b1110) begin errors++; $display("FAIL basic_accept: got %b expected 1110", {req_valid, new_req, floor_code}); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if ({req_valid, new_req, floor_code} !== 4'b0010) begin errors++; $display("FAIL basic_ack: got %b expected 0010", {req_valid, new_req, floor_code}); end
    release_all();
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      buttons = (i % 2 == 0) ? 4'b0010 : 4'b0000;
      tick();
      checks++; if ({req_valid, new_req, floor_code} !== 4'b0010) begin errors++; $display("FAIL bounce_cycle %0d: got %b expected 0010", i, {req_valid, new_req, floor_code}); end
    end
    buttons = 4'b0010;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if ({req_valid, new_req, floor_code} !== 4'b0010) begin errors++; $display("FAIL bounce_hold edge %0d: got %b expected 0010", i, {req_valid, new_req, floor_code}); end
    end
    tick();
    checks++; if ({req_valid, new_req, floor_code} !== 4'b1101) begin errors++; $display("FAIL bounce_accept: got %b expected 1101", {req_valid, new_req, floor_code}); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if (req_valid !== 1'b0) begin errors++; $display("FAIL bounce_ack: got %b expected 0", req_valid); end
    release_all();
  endtask

  task automatic test_simultaneous();
    buttons = 4'b1010;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if ({req_valid, new_req, floor_code} !== 4'b0001) begin errors++; $display("FAIL simul_wait edge %0d: got %b expected 0001", i, {req_valid, new_req, floor_code}); end
    end
    tick();
    checks++; if ({req_valid, new_req, floor_code} !== 4'b1101) begin errors++; $display("FAIL simul_accept: got %b expected 1101", {req_valid, new_req, floor_code}); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    release_all();
    // Second press switches from 1010 to 1000 while SETTLE is counting.
    buttons = 4'b1010;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 3) buttons = 4'b1000;
      checks++; if ({req_valid, new_req, floor_code} !== 4'b0001) begin errors++; $display("FAIL restart_wait edge %0d: got %b expected 0001", i, {req_valid, new_req, floor_code}); end
    end
    tick();
    checks++; if ({req_valid, new_req, floor_code} !== 4'b1111) begin errors++; $display("FAIL restart_accept: got %b expected 1111", {req_valid, new_req, floor_code}); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    release_all();
  endtask

  task automatic test_ack_hold();
    buttons = 4'b0100;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if ({req_valid, new_req, floor_code} !== 4'b0011) begin errors++; $display("FAIL ackhold_wait edge %0d: got %b expected 0011", i, {req_valid, new_req, floor_code}); end
    end
    tick();
    checks++; if ({req_valid, new_req, floor_code} !== 4'b1110) begin errors++; $display("FAIL ackhold_accept: got %b expected 1110", {req_valid, new_req, floor_code}); end
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++; if ({req_valid, new_req, floor_code} !== 4'b1010) begin errors++; $display("FAIL ackhold_pending cycle %0d: got %b expected 1010", i, {req_valid, new_req, floor_code}); end
    end
    ack = 1'b1;
    tick();
    checks++; if ({req_valid, new_req, floor_code} !== 4'b0010) begin errors++; $display("FAIL ackhold_ack: got %b expected 0010", {req_valid, new_req, floor_code}); end
    // Button stays held and ack stays high: nothing may be requested.
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if ({req_valid, new_req, floor_code} !== 4'b0010) begin errors++; $display("FAIL ackhold_held cycle %0d: got %b expected 0010", i, {req_valid, new_req, floor_code}); end
    end
    buttons = 4'd0; ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if ({req_valid, new_req, floor_code} !== 4'b0010) begin errors++; $display("FAIL ackhold_release cycle %0d: got %b expected 0010", i, {req_valid, new_req, floor_code}); end
    end
    buttons = 4'b0100;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if ({req_valid, new_req, floor_code} !== 4'b0010) begin errors++; $display("FAIL ackhold_repress edge %0d: got %b expected 0010", i, {req_valid, new_req, floor_code}); end
    end
    tick();
    checks++; if ({req_valid, new_req, floor_code} !== 4'b1110) begin errors++; $display("FAIL ackhold_reaccept: got %b expected 1110", {req_valid, new_req, floor_code}); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    release_all();
  endtask

  task automatic test_same_floor();
    buttons = 4'b0001;
    ack = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if ({req_valid, new_req, floor_code} !== 4'b0010) begin errors++; $display("FAIL same_wait edge %0d: got %b expected 0010", i, {req_valid, new_req, floor_code}); end
    end
    ack = 1'b0;
    tick();
    checks++; if ({req_valid, new_req, floor_code} !== 4'b1100) begin errors++; $display("FAIL same_accept1: got %b expected 1100", {req_valid, new_req, floor_code}); end
    tick();
    checks++; if ({req_valid, new_req, floor_code} !== 4'b1000) begin errors++; $display("FAIL same_pending1: got %b expected 1000", {req_valid, new_req, floor_code}); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++; if ({req_valid, new_req, floor_code} !== 4'b0000) begin errors++; $display("FAIL same_ack1: got %b expected 0000", {req_valid, new_req, floor_code}); end
    release_all();
    buttons = 4'b0001;
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if ({req_valid, new_req, floor_code} !== 4'b0000) begin errors++; $display("FAIL same_wait2 edge %0d: got %b expected 0000", i, {req_valid, new_req, floor_code}); end
    end
    tick();
    checks++; if ({req_valid, new_req, floor_code} !== 4'b1100) begin errors++; $display("FAIL same_accept2: got %b expected 1100", {req_valid, new_req, floor_code}); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    release_all();
  endtask

  task automatic test_reset_mid();
    buttons = 4'b1000;
    for (int i = 1; i <= 4; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({req_valid, new_req, floor_code} !== 4'b0000) begin errors++; $display("FAIL rst_settle: got %b expected 0000", {req_valid, new_req, floor_code}); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if ({req_valid, new_req, floor_code} !== 4'b0000) begin errors++; $display("FAIL rst_settle_wait edge %0d: got %b expected 0000", i, {req_valid, new_req, floor_code}); end
    end
    tick();
    checks++; if ({req_valid, new_req, floor_code} !== 4'b1111) begin errors++; $display("FAIL rst_settle_accept: got %b expected 1111", {req_valid, new_req, floor_code}); end
    tick();
    checks++; if ({req_valid, new_req, floor_code} !== 4'b1011) begin errors++; $display("FAIL rst_pending: got %b expected 1011", {req_valid, new_req, floor_code}); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({req_valid, new_req, floor_code} !== 4'b0000) begin errors++; $display("FAIL rst_pending_clear: got %b expected 0000", {req_valid, new_req, floor_code}); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      checks++; if ({req_valid, new_req, floor_code} !== 4'b0000) begin errors++; $display("FAIL rst_pending_wait edge %0d: got %b expected 0000", i, {req_valid, new_req, floor_code}); end
    end
    tick();
    checks++; if ({req_valid, new_req, floor_code} !== 4'b1111) begin errors++; $display("FAIL rst_pending_accept: got %b expected 1111", {req_valid, new_req, floor_code}); end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    release_all();
  endtask

  initial begin
    reset = 1'b1;
    buttons = 4'd0;
    ack = 1'b0;
    test_reset();
    test_basic();
    test_bounce();
    test_simultaneous();
    test_ack_hold();
    test_same_floor();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
